// File: rtl/logic_gate_n.sv
// logic_gate_n: clocked N-input gate with selectable function and transport or inertial delay
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over en)
//   en         clock enable; low freezes all state and forces tgl to 0
//   a[N-1:0]   gate inputs, sampled on rising clk
//   y          delayed gate output
//   tgl        one-cycle strobe in the cycle y takes a new value
//   glitch_cnt saturating count of suppressed pulses (inertial only, else 0)
module logic_gate_n #(
    parameter int N        = 2,
    parameter int MODE     = 0,
    parameter int TR       = 1,
    parameter bit INERTIAL = 1'b0,
    parameter bit RST_VAL  = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] a,
    output logic         y,
    output logic         tgl,
    output logic [7:0]   glitch_cnt
);
    logic f, y_nxt;
    if (N < 1 || N > 8 || (N == 1 && MODE != 6) || MODE < 0 || MODE > 6 || TR < 1 || TR > 255) begin : g_bad
        $error("logic_gate_n: illegal parameter combination");
    end
    always_comb f = (MODE == 0) ? &a :
                    (MODE == 1) ? ~&a :
                    (MODE == 2) ? |a :
                    (MODE == 3) ? ~|a :
                    (MODE == 4) ? ^a :
                    (MODE == 5) ? ~^a : ~a[0];
    if (!INERTIAL) begin : g_tr
        logic [TR-1:0] d;
        logic [TR:0]   c;
        // c is the whole chain with f at the bottom, so c[TR-1] is what y becomes next edge
        assign c          = {d, f};
        assign y          = d[TR-1];
        assign y_nxt      = c[TR-1];
        assign glitch_cnt = '0;
        always_ff @(posedge clk)
            if (rst) d <= {TR{RST_VAL}};
            else if (en) d <= c[TR-1:0];
    end else begin : g_in
        localparam int CW = $clog2(TR + 1);
        logic [CW-1:0] cnt;
        logic [7:0]    gc;
        logic          yq, hit;
        // f has differed from y for TR sampled edges once this edge completes
        assign hit        = (f != yq) && (cnt == CW'(TR - 1));
        assign y_nxt      = hit ? f : yq;
        assign y          = yq;
        assign glitch_cnt = gc;
        always_ff @(posedge clk)
            if (rst) begin
                yq  <= RST_VAL;
                cnt <= '0;
                gc  <= '0;
            end else if (en) begin
                yq <= y_nxt;
                if (f == yq) begin
                    cnt <= '0;
                    if (cnt != '0 && gc != 8'hff) gc <= gc + 8'd1;
                end else cnt <= hit ? '0 : cnt + CW'(1);
            end
    end
    always_ff @(posedge clk)
        if (rst) tgl <= 1'b0;
        else tgl <= en && (y_nxt != y);
endmodule

// File: tb/tb_logic_gate_n.sv
// tb_logic_gate_n: scoreboard bench for logic_gate_n across six parameterisations
module tb_logic_gate_n;
    typedef struct packed {
        logic       y;
        logic       t;
        logic [7:0] g;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] en  = '1;
    logic [2:0] a0  = '0;
    logic [1:0] a1  = '0, a3 = '0, a4 = '0, a5 = '0;
    logic [7:0] a2  = '0;
    logic [5:0] y, tg;
    logic [7:0] gc [6];
    exp_t       q[$];
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    logic_gate_n #(.N(3), .MODE(0), .TR(4), .INERTIAL(1'b0), .RST_VAL(1'b0)) u0 (
        .clk(clk), .rst(rst), .en(en[0]), .a(a0), .y(y[0]), .tgl(tg[0]), .glitch_cnt(gc[0]));
    logic_gate_n #(.N(2), .MODE(3), .TR(3), .INERTIAL(1'b1), .RST_VAL(1'b0)) u1 (
        .clk(clk), .rst(rst), .en(en[1]), .a(a1), .y(y[1]), .tgl(tg[1]), .glitch_cnt(gc[1]));
    logic_gate_n #(.N(8), .MODE(4), .TR(1), .INERTIAL(1'b0), .RST_VAL(1'b0)) u2 (
        .clk(clk), .rst(rst), .en(en[2]), .a(a2), .y(y[2]), .tgl(tg[2]), .glitch_cnt(gc[2]));
    logic_gate_n #(.N(2), .MODE(0), .TR(4), .INERTIAL(1'b1), .RST_VAL(1'b0)) u3 (
        .clk(clk), .rst(rst), .en(en[3]), .a(a3), .y(y[3]), .tgl(tg[3]), .glitch_cnt(gc[3]));
    logic_gate_n #(.N(2), .MODE(2), .TR(5), .INERTIAL(1'b0), .RST_VAL(1'b1)) u4 (
        .clk(clk), .rst(rst), .en(en[4]), .a(a4), .y(y[4]), .tgl(tg[4]), .glitch_cnt(gc[4]));
    logic_gate_n #(.N(2), .MODE(4), .TR(2), .INERTIAL(1'b1), .RST_VAL(1'b0)) u5 (
        .clk(clk), .rst(rst), .en(en[5]), .a(a5), .y(y[5]), .tgl(tg[5]), .glitch_cnt(gc[5]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = '1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] ry = 6'b010000;
        a0 = '1; a1 = '1; a2 = '1; a3 = '1; a4 = '0; a5 = '1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tests++;
            if ({y[i], tg[i], gc[i]} !== {ry[i], 1'b0, 8'd0}) begin
                fails++;
                $display("FAIL reset[u%0d]: got y=%b tgl=%b gc=%0d, want y=%b tgl=0 gc=0", i, y[i], tg[i], gc[i], ry[i]);
            end
        end
    endtask

    task automatic test_transport_and();
        exp_t e;
        logic [2:0] st [8] = '{3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        int ey [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        int et [8] = '{0, 0, 0, 1, 1, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a0 = st[i];
            q.push_back({1'(ey[i]), 1'(et[i]), 8'd0});
            tick();
            e = q.pop_front();
            tests++;
            if ({y[0], tg[0], gc[0]} !== e) begin
                fails++;
                $display("FAIL and_tr[%0d]: got y=%b tgl=%b gc=%0d, want y=%b tgl=%b gc=%0d", i, y[0], tg[0], gc[0], e.y, e.t, e.g);
            end
        end
    endtask

    task automatic test_inertial_nor();
        exp_t e;
        logic [1:0] st [11] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
        int ey [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        int et [11] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
        int eg [11] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            a1 = st[i];
            q.push_back({1'(ey[i]), 1'(et[i]), 8'(eg[i])});
            tick();
            e = q.pop_front();
            tests++;
            if ({y[1], tg[1], gc[1]} !== e) begin
                fails++;
                $display("FAIL nor_in[%0d]: got y=%b tgl=%b gc=%0d, want y=%b tgl=%b gc=%0d", i, y[1], tg[1], gc[1], e.y, e.t, e.g);
            end
        end
    endtask

    task automatic test_xor8();
        exp_t e;
        logic [7:0] v;
        logic       p, prev = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            v = (i == 0) ? 8'hA5 : (i == 1) ? 8'hA4 : 8'($urandom);
            p = ($countones(v) % 2) == 1;
            a2 = v;
            q.push_back({p, p != prev, 8'd0});
            prev = p;
            tick();
            e = q.pop_front();
            tests++;
            if ({y[2], tg[2], gc[2]} !== e) begin
                fails++;
                $display("FAIL xor8[%0d] a=%h: got y=%b tgl=%b, want y=%b tgl=%b", i, v, y[2], tg[2], e.y, e.t);
            end
        end
    endtask

    task automatic test_en_gating();
        exp_t e;
        int ee [10] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
        logic [1:0] st [10] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11};
        int ey [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        int et [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            en[3] = 1'(ee[i]);
            a3 = st[i];
            q.push_back({1'(ey[i]), 1'(et[i]), 8'd0});
            tick();
            e = q.pop_front();
            tests++;
            if ({y[3], tg[3], gc[3]} !== e) begin
                fails++;
                $display("FAIL en_gate[%0d]: got y=%b tgl=%b gc=%0d, want y=%b tgl=%b gc=%0d", i, y[3], tg[3], gc[3], e.y, e.t, e.g);
            end
        end
        en = '1;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [1:0] st [14] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            a4 = st[i];
            rst = (i == 5);
            q.push_back({1'b1, 1'b0, 8'd0});
            tick();
            e = q.pop_front();
            tests++;
            if ({y[4], tg[4]} !== {e.y, e.t}) begin
                fails++;
                $display("FAIL rst_mid[%0d]: got y=%b tgl=%b, want y=%b tgl=%b", i, y[4], tg[4], e.y, e.t);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_glitch_sat();
        exp_t e;
        int n;
        do_reset();
        for (int i = 0; i < 605; i++) begin
            n = (i + 1) / 2;
            a5 = (i < 600 && i % 2 == 0) ? 2'b01 : 2'b00;
            q.push_back({1'b0, 1'b0, 8'((n > 255) ? 255 : n)});
            tick();
            e = q.pop_front();
            tests++;
            if ({y[5], tg[5], gc[5]} !== e) begin
                fails++;
                $display("FAIL glitch_sat[%0d]: got y=%b tgl=%b gc=%0d, want y=%b tgl=%b gc=%0d", i, y[5], tg[5], gc[5], e.y, e.t, e.g);
            end
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_transport_and();
        test_inertial_nor();
        test_xor8();
        test_en_gating();
        test_reset_mid();
        test_glitch_sat();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
